cache_ctrl: RTL

- Direct-mapped cache controller placed directly upstream of the 4-entry x 36-bit cache data store.
- Accepts single read/write requests from the CPU side and holds tag/valid state for the 4 lines.
- Drives the data store's address/data/rden/wren pins and fetches from main memory on misses.
- Write-through, no-write-allocate; maintains saturating hit/miss counters.

---
 rtl/cache_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Direct-mapped, 4-line cache controller sitting in front of a 4 x DATA_W data
// store. Tag/valid state lives here; line data lives in the external store.
// Write-through, no-write-allocate. Misses are serviced from main memory and
// filled into the store. Hit and miss lookups are counted with saturation.
//
// Ports
//   clock, i_rst                 clock, synchronous active-high reset
//   req_*                        CPU request channel (accepted only in IDLE)
//   resp_*                       CPU response channel (valid/ready)
//   st_address/st_data/st_rden/st_wren, st_q
//                                data store pins; st_q is combinational
//                                from st_address
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata
//                                main memory; request held until mem_ack
//   hit_count, miss_count        saturating lookup statistics
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | ready for a request; request fields captured on req_valid
// LOOKUP   | tag compare against store index; write-hit updates the store
// MEM_RD   | read miss, waiting for main memory data
// FILL     | write fetched line into the store, update tag/valid
// MEM_WR   | write-through to main memory
// RESP     | response presented until the CPU accepts it
// -----------------------------------------------------------------------------
module cache_ctrl #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 36,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                i_rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [TAG_W+1:0]    req_addr,
    input  logic [DATA_W-1:0]   req_wdata,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,

    output logic [1:0]          st_address,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_rden,
    output logic                st_wren,
    input  logic [DATA_W-1:0]   st_q,

    output logic                mem_req,
    output logic                mem_we,
    output logic [TAG_W+1:0]    mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]         r_state;
    logic [3:0]         r_valid;
    logic [TAG_W-1:0]   r_tag [4];
    logic               r_req_we;
    logic [TAG_W+1:0]   r_req_addr;
    logic [DATA_W-1:0]  r_req_wdata;
    logic [DATA_W-1:0]  r_fill_data;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [1:0]         w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;

    assign w_idx = r_req_addr[1:0];
    assign w_tag = r_req_addr[TAG_W+1:2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i] <= '0;
            end
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_fill_data  <= '0;
            r_resp_rdata <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_we    <= req_we;
                        r_req_addr  <= req_addr;
                        r_req_wdata <= req_wdata;
                        r_state     <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    // Counters stick at all-ones rather than wrapping.
                    if (w_hit) begin
                        if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                    end

                    if (r_req_we) begin
                        r_state <= S_MEM_WR;
                    end else if (w_hit) begin
                        r_resp_rdata <= st_q;
                        r_state      <= S_RESP;
                    end else begin
                        r_state <= S_MEM_RD;
                    end
                end

                S_MEM_RD: begin
                    if (mem_ack) begin
                        r_fill_data <= mem_rdata;
                        r_state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    // Any previous occupant is simply overwritten: memory
                    // already holds its data because every write goes through.
                    r_valid[w_idx] <= 1'b1;
                    r_tag[w_idx]   <= w_tag;
                    r_resp_rdata   <= r_fill_data;
                    r_state        <= S_RESP;
                end

                S_MEM_WR: begin
                    if (mem_ack) begin
                        r_resp_rdata <= '0;
                        r_state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        st_address = 2'd0;
        st_data    = '0;
        st_rden    = 1'b0;
        st_wren    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
            end

            S_LOOKUP: begin
                st_address = w_idx;
                st_rden    = 1'b1;
                // Write hit keeps the cached copy coherent with the
                // write-through value; write miss does not allocate.
                if (r_req_we && w_hit) begin
                    st_wren = 1'b1;
                    st_data = r_req_wdata;
                end
            end

            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_req_addr;
            end

            S_FILL: begin
                st_address = w_idx;
                st_wren    = 1'b1;
                st_data    = r_fill_data;
            end

            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_req_addr;
                mem_wdata = r_req_wdata;
            end

            S_RESP: begin
                resp_valid = 1'b1;
            end

            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign resp_rdata = r_resp_rdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule
